// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Definitions shared by the write-side and read-side FIFO controllers:
//   - default geometry (DEF_DEPTH address bits, DEF_WIDTH data bits)
//   - default almost-full level
//   - write-side debug state encoding
//   - binary <-> Gray conversion helpers
// The helpers operate on a fixed 32-bit word. Callers zero-extend their
// pointer into the helper and cast the result back to the pointer width.
// Zero-extension is harmless because the upper bits stay zero in both
// directions.
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEF_DEPTH     = 7;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_AF_THRESH = 120;
   localparam int PTR_MAX       = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WRITE = 2'b01,
      ST_STALL = 2'b11
   } wr_state_e;

   function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of every Gray bit at or above it.
   function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
      logic [PTR_MAX-1:0] b;
      b[PTR_MAX-1] = g[PTR_MAX-1];
      for (int i = PTR_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/write_logic_ctrl_if.sv
// ---------------------------------------------------------------------------
// write_logic_ctrl_if
// Bundles the producer request and the RAM write port of the FIFO write side.
//   insert       producer -> controller   write request
//   wr_data      producer -> controller   data accompanying insert
//   write_addr   controller -> RAM        write address
//   mem_wdata    controller -> RAM        write data
//   write_enable controller -> RAM        one strobe per accepted word
// The master modport is the producer/RAM side.
// The slave modport is the write controller.
// ---------------------------------------------------------------------------
interface write_logic_ctrl_if
   import fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH
);
   logic             insert;
   logic [WIDTH-1:0] wr_data;
   logic [DEPTH-1:0] write_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             write_enable;

   modport master (
      output insert, wr_data,
      input  write_addr, mem_wdata, write_enable
   );

   modport slave (
      input  insert, wr_data,
      output write_addr, mem_wdata, write_enable
   );
endinterface

// File: rtl/ptr_sync_2ff.sv
// ---------------------------------------------------------------------------
// ptr_sync_2ff
// Two-flop synchroniser for a Gray-coded pointer crossing into this domain.
// It is used on both the write side and the read side of the FIFO.
//   clk    destination-domain clock, rising edge
//   rst_n  asynchronous active-low reset (clears both stages)
//   clr    synchronous clear, same effect as reset on the next edge
//   d_i    pointer from the other clock domain (unsynchronised)
//   q_o    pointer after two destination-domain flops
// ---------------------------------------------------------------------------
module ptr_sync_2ff #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] rq1_q, rq1_d;
   logic [W-1:0] rq2_q, rq2_d;

   always_comb begin
      rq1_d = clr ? '0 : d_i;
      rq2_d = clr ? '0 : rq1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= rq1_d;
         rq2_q <= rq2_d;
      end
   end

   assign q_o = rq2_q;

endmodule

// File: rtl/write_logic_ctrl.sv
// ---------------------------------------------------------------------------
// write_logic_ctrl
// Producer end of the asynchronous FIFO.
// It accepts insert requests and drives the dual-port RAM write port.
// It keeps the binary and Gray write pointers, synchronises the read-side
// Gray pointer, and reports full, almost_full, sticky overflow and occupancy.
//   clk_out      write-domain clock
//   reset        asynchronous active-low reset
//   syn_flush    synchronous flush (reset-equivalent on next edge, beats insert)
//   wr_if        slave: insert/wr_data in, write_addr/mem_wdata/write_enable out
//   rptr_gray    read pointer (Gray) from the read clock domain
//   wptr         binary write pointer
//   wptr_gray    registered Gray write pointer for the read-side synchroniser
//   full         no free entry
//   almost_full  occupancy >= AF_THRESH
//   overflow     sticky: insert attempted while full
//   wr_count     write-side occupancy; lags read-side removals by 2-3 cycles
// ---------------------------------------------------------------------------
module write_logic_ctrl
   import fifo_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int AF_THRESH = DEF_AF_THRESH
) (
   input  logic               clk_out,
   input  logic               reset,
   input  logic               syn_flush,
   write_logic_ctrl_if.slave  wr_if,
   input  logic [DEPTH:0]     rptr_gray,
   output logic [DEPTH:0]     wptr,
   output logic [DEPTH:0]     wptr_gray,
   output logic               full,
   output logic               almost_full,
   output logic               overflow,
   output logic [DEPTH:0]     wr_count
);

   localparam int PW = DEPTH + 1;

   logic [DEPTH:0] rq2;
   logic [DEPTH:0] rbin;

   logic [DEPTH:0]   wptr_q, wptr_d;
   logic [DEPTH:0]   wptr_gray_q, wptr_gray_d;
   logic [DEPTH-1:0] write_addr_q, write_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic             write_enable_q, write_enable_d;
   logic             full_q, full_d;
   logic             almost_full_q, almost_full_d;
   logic             overflow_q, overflow_d;
   wr_state_e        state_q, state_d;

   logic             accepted;
   logic [DEPTH:0]   count_next;

   ptr_sync_2ff #(.W(PW)) u_rptr_sync (
      .clk   (clk_out),
      .rst_n (reset),
      .clr   (syn_flush),
      .d_i   (rptr_gray),
      .q_o   (rq2)
   );

   assign rbin = PW'(gray2bin(PTR_MAX'(rq2)));

   // Datapath next-state
   always_comb begin
      accepted       = wr_if.insert & ~full_q;

      wptr_d         = wptr_q;
      write_addr_d   = write_addr_q;
      mem_wdata_d    = mem_wdata_q;
      write_enable_d = 1'b0;

      if (accepted) begin
         wptr_d         = wptr_q + 1'b1;
         write_addr_d   = wptr_q[DEPTH-1:0];
         mem_wdata_d    = wr_if.wr_data;
         write_enable_d = 1'b1;
      end

      wptr_gray_d = PW'(bin2gray(PTR_MAX'(wptr_d)));

      // Full and almost-full are computed from the post-edge pointer.
      // As a result, full rises on the same edge that fills the last slot.
      // No later insert can slip in while full is set.
      count_next    = wptr_d - rbin;
      full_d        = (wptr_d[DEPTH] != rbin[DEPTH]) &&
                      (wptr_d[DEPTH-1:0] == rbin[DEPTH-1:0]);
      almost_full_d = (count_next >= PW'(AF_THRESH));

      overflow_d    = overflow_q | (wr_if.insert & full_q);

      if (syn_flush) begin
         wptr_d         = '0;
         wptr_gray_d    = '0;
         write_addr_d   = '0;
         mem_wdata_d    = '0;
         write_enable_d = 1'b0;
         full_d         = 1'b0;
         almost_full_d  = 1'b0;
         overflow_d     = 1'b0;
      end
   end

   // Debug-only state tracking: the datapath never looks at it
   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (accepted)          state_d = ST_WRITE;
            else if (wr_if.insert) state_d = ST_STALL;
            else                   state_d = ST_IDLE;
         end
         ST_WRITE: begin
            if (accepted)    state_d = ST_WRITE;
            else if (full_q) state_d = ST_STALL;
            else             state_d = ST_IDLE;
         end
         ST_STALL: begin
            if (!full_q) state_d = wr_if.insert ? ST_WRITE : ST_IDLE;
            else         state_d = ST_STALL;
         end
         default: state_d = ST_IDLE;
      endcase
      if (syn_flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk_out or negedge reset) begin
      if (!reset) begin
         wptr_q         <= '0;
         wptr_gray_q    <= '0;
         write_addr_q   <= '0;
         mem_wdata_q    <= '0;
         write_enable_q <= 1'b0;
         full_q         <= 1'b0;
         almost_full_q  <= 1'b0;
         overflow_q     <= 1'b0;
         state_q        <= ST_IDLE;
      end else begin
         wptr_q         <= wptr_d;
         wptr_gray_q    <= wptr_gray_d;
         write_addr_q   <= write_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         write_enable_q <= write_enable_d;
         full_q         <= full_d;
         almost_full_q  <= almost_full_d;
         overflow_q     <= overflow_d;
         state_q        <= state_d;
      end
   end

   assign wr_if.write_addr   = write_addr_q;
   assign wr_if.mem_wdata    = mem_wdata_q;
   assign wr_if.write_enable = write_enable_q;
   assign wptr               = wptr_q;
   assign wptr_gray          = wptr_gray_q;
   assign full               = full_q;
   assign almost_full        = almost_full_q;
   assign overflow           = overflow_q;
   assign wr_count           = wptr_q - rbin;

endmodule

// File: tb/tb_write_logic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_write_logic_ctrl
// Randomised bench for the FIFO write-side controller.
// A behavioural model tracks the write pointer count, the occupancy as an
// integer, and the read pointer as seen two edges late.
// Every clock step compares all outputs against that model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_write_logic_ctrl;

   localparam int DEPTH = 7;
   localparam int WIDTH = 8;
   localparam int AF    = 120;
   localparam int CAP   = 128;
   localparam int MODP  = 256;

   logic       clk_out = 1'b0;
   logic       reset;
   logic       syn_flush;
   logic [7:0] rptr_gray;
   logic [7:0] wptr;
   logic [7:0] wptr_gray;
   logic [7:0] wr_count;
   logic       full;
   logic       almost_full;
   logic       overflow;

   write_logic_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) wr_if ();

   write_logic_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(AF)) dut (
      .clk_out     (clk_out),
      .reset       (reset),
      .syn_flush   (syn_flush),
      .wr_if       (wr_if),
      .rptr_gray   (rptr_gray),
      .wptr        (wptr),
      .wptr_gray   (wptr_gray),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow),
      .wr_count    (wr_count)
   );

   always #5 clk_out = ~clk_out;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state (plain integers)
   int m_wptr, m_addr, m_data, m_we, m_full, m_af, m_ovf, m_state;
   int rp_last;   // read pointer sampled at the most recent edge
   int rp_prev;   // read pointer sampled one edge before that (what the DUT sees)

   task automatic model_clear();
      m_wptr = 0; m_addr = 0; m_data = 0; m_we = 0;
      m_full = 0; m_af = 0; m_ovf = 0; m_state = 0;
      rp_last = 0; rp_prev = 0;
   endtask

   // One clock: drive inputs, advance the model on the edge, compare #1 later
   task automatic step(input bit ins, input logic [7:0] d, input bit fl, input int rp);
      logic [7:0] rpb;
      int  seen;
      int  occ;
      bit  acc;
      rpb             = rp[7:0];
      wr_if.insert    = ins;
      wr_if.wr_data   = d;
      syn_flush       = fl;
      rptr_gray       = rpb ^ (rpb >> 1);
      @(posedge clk_out);
      if (!reset || fl) begin
         model_clear();
      end else begin
         seen = rp_prev;
         acc  = ins && (m_full == 0);
         case (m_state)
            0:       m_state = acc ? 1 : (ins ? 3 : 0);
            1:       m_state = acc ? 1 : ((m_full != 0) ? 3 : 0);
            3:       m_state = (m_full == 0) ? (ins ? 1 : 0) : 3;
            default: m_state = 0;
         endcase
         if (ins && m_full != 0) m_ovf = 1;
         if (acc) begin
            m_addr = m_wptr % CAP;
            m_data = int'(d);
            m_we   = 1;
            m_wptr = (m_wptr + 1) % MODP;
         end else begin
            m_we = 0;
         end
         occ    = (m_wptr - seen + MODP) % MODP;
         m_full = (occ == CAP) ? 1 : 0;
         m_af   = (occ >= AF) ? 1 : 0;
         rp_prev = rp_last;
         rp_last = rp % MODP;
      end
      #1;
      check_eq("wptr",         wptr,                 m_wptr);
      check_eq("wptr_gray",    wptr_gray,            m_wptr ^ (m_wptr >> 1));
      check_eq("write_addr",   wr_if.write_addr,     m_addr);
      check_eq("mem_wdata",    wr_if.mem_wdata,      m_data);
      check_eq("write_enable", wr_if.write_enable,   m_we);
      check_eq("full",         full,                 m_full);
      check_eq("almost_full",  almost_full,          m_af);
      check_eq("overflow",     overflow,             m_ovf);
      check_eq("wr_count",     wr_count,             (m_wptr - rp_prev + MODP) % MODP);
      check_eq("state",        32'(dut.state_q),     m_state);
   endtask

   initial begin
      int  rp;
      int  edges;
      int  wraps;
      bit  ins;
      bit  fl;
      logic [7:0] prev_g;
      logic [7:0] prev_w;

      model_clear();
      reset         = 1'b0;
      syn_flush     = 1'b0;
      wr_if.insert  = 1'b1;
      wr_if.wr_data = 8'h00;
      rptr_gray     = 8'h00;
      #2;

      // Reset held low with insert asserted: nothing may be written
      repeat (3) step(1'b1, 8'h5A, 1'b0, 0);
      check_eq("rst_we", wr_if.write_enable, 0);
      check_eq("rst_wptr", wptr, 0);
      reset = 1'b1;

      // Fill all 128 entries with the read side idle
      for (int i = 0; i < CAP; i++) begin
         step(1'b1, 8'($urandom), 1'b0, 0);
         if (i == 0)   check_eq("first_addr", wr_if.write_addr, 0);
         if (i == 118) check_eq("af_before_120", almost_full, 0);
         if (i == 119) check_eq("af_at_120", almost_full, 1);
         if (i == 126) check_eq("not_full_127", full, 0);
      end
      check_eq("fill_full", full, 1);
      check_eq("fill_count", wr_count, 128);
      check_eq("fill_last_addr", wr_if.write_addr, 127);

      // Insert while full: dropped, overflow set
      step(1'b1, 8'hAA, 1'b0, 0);
      check_eq("ovf_set", overflow, 1);
      check_eq("ovf_no_we", wr_if.write_enable, 0);
      check_eq("ovf_wptr", wptr, 8'h80);

      // One read on the far side: full must clear after exactly 3 edges
      rp = 1;
      edges = 0;
      while (full && edges < 10) begin
         step(1'b0, 8'h00, 1'b0, rp);
         edges++;
      end
      check_eq("full_clear_edges", edges, 3);
      step(1'b1, 8'h3C, 1'b0, rp);
      check_eq("refill_addr", wr_if.write_addr, 0);
      check_eq("refill_we", wr_if.write_enable, 1);

      // Wrap with the reader keeping pace
      wraps  = 0;
      prev_g = wptr_gray;
      prev_w = wptr;
      for (int i = 0; i < 400; i++) begin
         ins = ($urandom % 4) != 0;
         if (((m_wptr - rp + MODP) % MODP) != 0 && ($urandom % 8) != 0) rp = (rp + 1) % MODP;
         step(ins, 8'($urandom), 1'b0, rp);
         check_eq("gray_step_bits", $countones(prev_g ^ wptr_gray), m_we);
         if (prev_w == 8'hFF && wptr == 8'h00) wraps++;
         prev_g = wptr_gray;
         prev_w = wptr;
      end
      check_eq("wrap_seen", (wraps > 0) ? 1 : 0, 1);

      // Flush in the middle of a burst
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, rp);
      step(1'b1, 8'hEE, 1'b1, 0);
      rp = 0;
      check_eq("flush_we", wr_if.write_enable, 0);
      check_eq("flush_ovf", overflow, 0);
      check_eq("flush_wptr", wptr, 0);
      check_eq("flush_state", 32'(dut.state_q), 0);

      // Random mix with occasional flushes and a lagging reader
      for (int i = 0; i < 300; i++) begin
         fl  = ($urandom % 40) == 0;
         ins = ($urandom % 3) != 0;
         if (fl) rp = 0;
         else if (((m_wptr - rp + MODP) % MODP) != 0 && ($urandom % 3) == 0) rp = (rp + 1) % MODP;
         step(ins, 8'($urandom), fl, rp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
